pipelined_decode: RTL and testbench

Parametrised MIPS instruction-decode stage with an integrated register file and an ID/EX output register. Sits between fetch and execute, with valid/ready handshakes on both sides. A write-back port feeds the register file. Detects load-use hazards against the instruction it holds and inserts one bubble.

---
 rtl/pipelined_decode_pkg.sv | 25 ++
 rtl/pipelined_decode_if.sv | 32 +++
 rtl/pipelined_decode_register_file.sv | 56 +++++
 rtl/pipelined_decode.sv | 117 +++++++++++
 tb/tb_pipelined_decode.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipelined_decode_pkg.sv
// rtl/pipelined_decode_pkg.sv - decode_pkg: opcodes, instruction field positions, register index width
package decode_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    function automatic int reg_index_width(input int reg_count);
        return $clog2(reg_count);
    endfunction

endpackage

// File: rtl/pipelined_decode_if.sv
// rtl/pipelined_decode_if.sv - fetch, write-back and execute signals of the decode stage
interface pipelined_decode_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  instructionValid;
    logic [31:0]           instruction;
    logic                  instructionReady;
    logic                  writeEnable;
    logic [4:0]            writeRegister;
    logic [DATA_WIDTH-1:0] writeData;
    logic                  decodeValid;
    logic                  decodeReady;
    logic [5:0]            opCode;
    logic [DATA_WIDTH-1:0] readDataNumberOne;
    logic [DATA_WIDTH-1:0] readDataNumberTwo;
    logic [DATA_WIDTH-1:0] signExtendedImmediate;
    logic [4:0]            rt;
    logic [4:0]            rd;
    logic                  hazardStall;

    modport slave (
        input  instructionValid, instruction, writeEnable, writeRegister, writeData, decodeReady,
        output instructionReady, decodeValid, opCode, readDataNumberOne, readDataNumberTwo,
               signExtendedImmediate, rt, rd, hazardStall
    );

    modport master (
        output instructionValid, instruction, writeEnable, writeRegister, writeData, decodeReady,
        input  instructionReady, decodeValid, opCode, readDataNumberOne, readDataNumberTwo,
               signExtendedImmediate, rt, rd, hazardStall
    );
endinterface

// File: rtl/pipelined_decode_register_file.sv
// rtl/pipelined_decode_register_file.sv - register_file: 2 async read ports, 1 write port, r0 hardwired 0
// Optional write-to-read forwarding under REGFILE_BYPASS_EN.
module register_file
    import decode_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic [4:0]            read_addr_a_i,
    input  logic [4:0]            read_addr_b_i,
    output logic [DATA_WIDTH-1:0] read_data_a_o,
    output logic [DATA_WIDTH-1:0] read_data_b_o,
    input  logic                  write_enable_i,
    input  logic [4:0]            write_addr_i,
    input  logic [DATA_WIDTH-1:0] write_data_i
);
    localparam int IW = reg_index_width(REG_COUNT);

    logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
    logic [IW-1:0]         write_index;
    logic [IW-1:0]         read_index_a;
    logic [IW-1:0]         read_index_b;
    logic                  write_hit;

    // Truncated indices: an address aliasing onto r0 must never write it.
    assign write_index  = write_addr_i[IW-1:0];
    assign read_index_a = read_addr_a_i[IW-1:0];
    assign read_index_b = read_addr_b_i[IW-1:0];
    assign write_hit    = write_enable_i && (write_index != '0);

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
        end else if (write_hit) begin
            regs_q[write_index] <= write_data_i;
        end
    end

    always_comb begin
        read_data_a_o = (read_index_a == '0) ? '0 : regs_q[read_index_a];
        read_data_b_o = (read_index_b == '0) ? '0 : regs_q[read_index_b];
`ifdef REGFILE_BYPASS_EN
        if (write_hit && (write_index == read_index_a)) begin
            read_data_a_o = write_data_i;
        end
        if (write_hit && (write_index == read_index_b)) begin
            read_data_b_o = write_data_i;
        end
`endif
    end

endmodule

// File: rtl/pipelined_decode.sv
// rtl/pipelined_decode.sv - MIPS decode stage: register file, load-use bubble, ID/EX register
// Build option REGFILE_BYPASS_EN forwards same-edge write-back data into captured operands.
module pipelined_decode
    import decode_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32
) (
    input logic               clock,
    input logic               resetN,
    pipelined_decode_if.slave bus
);
    logic [31:0]           instr;
    logic [5:0]            in_op;
    logic [4:0]            in_rs;
    logic [4:0]            in_rt;
    logic [DATA_WIDTH-1:0] rf_data_a;
    logic [DATA_WIDTH-1:0] rf_data_b;

    logic                  decode_valid_q, decode_valid_d;
    logic [5:0]            op_code_q, op_code_d;
    logic [DATA_WIDTH-1:0] read_one_q, read_one_d;
    logic [DATA_WIDTH-1:0] read_two_q, read_two_d;
    logic [DATA_WIDTH-1:0] imm_q, imm_d;
    logic [4:0]            rt_q, rt_d;
    logic [4:0]            rd_q, rd_d;

    logic advance;
    logic uses_rt;
    logic hazard;
    logic hazard_stall;
    logic instruction_ready;
    logic capture;

    assign instr = bus.instruction;
    assign in_op = instr[OP_MSB:OP_LSB];
    assign in_rs = instr[RS_MSB:RS_LSB];
    assign in_rt = instr[RT_MSB:RT_LSB];

    register_file #(
        .DATA_WIDTH(DATA_WIDTH),
        .REG_COUNT (REG_COUNT)
    ) u_register_file (
        .clock         (clock),
        .resetN        (resetN),
        .read_addr_a_i (in_rs),
        .read_addr_b_i (in_rt),
        .read_data_a_o (rf_data_a),
        .read_data_b_o (rf_data_b),
        .write_enable_i(bus.writeEnable),
        .write_addr_i  (bus.writeRegister),
        .write_data_i  (bus.writeData)
    );

    // Load-use check against the held lw; rt of the incoming word only matters when it is a source.
    assign advance      = !decode_valid_q || bus.decodeReady;
    assign uses_rt      = (in_op == OP_RTYPE) || (in_op == OP_SW) ||
                          (in_op == OP_BEQ)   || (in_op == OP_BNE);
    assign hazard       = decode_valid_q && (op_code_q == OP_LW) && (rt_q != 5'd0) &&
                          ((rt_q == in_rs) || (uses_rt && (rt_q == in_rt)));
    assign hazard_stall = hazard && bus.instructionValid;
    assign instruction_ready = advance && !hazard_stall;
    assign capture      = bus.instructionValid && instruction_ready;

    always_comb begin
        decode_valid_d = decode_valid_q;
        op_code_d      = op_code_q;
        read_one_d     = read_one_q;
        read_two_d     = read_two_q;
        imm_d          = imm_q;
        rt_d           = rt_q;
        rd_d           = rd_q;
        if (capture) begin
            decode_valid_d = 1'b1;
            op_code_d      = in_op;
            read_one_d     = rf_data_a;
            read_two_d     = rf_data_b;
            imm_d          = {{(DATA_WIDTH-16){instr[IMM_MSB]}}, instr[IMM_MSB:IMM_LSB]};
            rt_d           = in_rt;
            rd_d           = instr[RD_MSB:RD_LSB];
        end else if (advance) begin
            // Bubble or drain: slot empties, payload fields are left as they were.
            decode_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            decode_valid_q <= 1'b0;
            op_code_q      <= '0;
            read_one_q     <= '0;
            read_two_q     <= '0;
            imm_q          <= '0;
            rt_q           <= '0;
            rd_q           <= '0;
        end else begin
            decode_valid_q <= decode_valid_d;
            op_code_q      <= op_code_d;
            read_one_q     <= read_one_d;
            read_two_q     <= read_two_d;
            imm_q          <= imm_d;
            rt_q           <= rt_d;
            rd_q           <= rd_d;
        end
    end

    assign bus.instructionReady      = instruction_ready;
    assign bus.hazardStall           = hazard_stall;
    assign bus.decodeValid           = decode_valid_q;
    assign bus.opCode                = op_code_q;
    assign bus.readDataNumberOne     = read_one_q;
    assign bus.readDataNumberTwo     = read_two_q;
    assign bus.signExtendedImmediate = imm_q;
    assign bus.rt                    = rt_q;
    assign bus.rd                    = rd_q;

endmodule

// File: tb/tb_pipelined_decode.sv
// tb/tb_pipelined_decode.sv - directed vector bench for pipelined_decode
module tb_pipelined_decode;

    localparam int DW = 32;

    typedef struct {
        logic [31:0]   instr;
        logic [5:0]    op;
        logic [DW-1:0] r1;
        logic [DW-1:0] r2;
        logic [DW-1:0] imm;
        logic [4:0]    rt;
        logic [4:0]    rd;
    } vec_t;

    logic clock;
    logic resetN;
    int   total_count;
    int   pass_count;
    vec_t vecs [4];

    pipelined_decode_if #(.DATA_WIDTH(DW)) bus ();

    pipelined_decode #(
        .DATA_WIDTH(DW),
        .REG_COUNT (32)
    ) dut (
        .clock (clock),
        .resetN(resetN),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_count++;
        if (act === exp) begin
            pass_count++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] idx, input logic [DW-1:0] val);
        bus.writeEnable   = 1'b1;
        bus.writeRegister = idx;
        bus.writeData     = val;
        step();
        bus.writeEnable   = 1'b0;
    endtask

    task automatic present(input logic [31:0] word);
        bus.instructionValid = 1'b1;
        bus.instruction      = word;
    endtask

    task automatic check_fields(input string tag, input vec_t v);
        check({tag, " valid"}, 64'(bus.decodeValid), 64'd1);
        check({tag, " op"},    64'(bus.opCode), 64'(v.op));
        check({tag, " r1"},    64'(bus.readDataNumberOne), 64'(v.r1));
        check({tag, " r2"},    64'(bus.readDataNumberTwo), 64'(v.r2));
        check({tag, " imm"},   64'(bus.signExtendedImmediate), 64'(v.imm));
        check({tag, " rt"},    64'(bus.rt), 64'(v.rt));
        check({tag, " rd"},    64'(bus.rd), 64'(v.rd));
    endtask

    initial begin
        logic [DW-1:0] exp_same_edge;
        total_count = 0;
        pass_count  = 0;

        vecs[0] = '{32'h0022_1800, 6'h00, 32'd5, 32'd7, 32'h0000_1800, 5'd2, 5'd3};
        vecs[1] = '{32'h2001_FFFF, 6'h08, 32'd0, 32'd5, 32'hFFFF_FFFF, 5'd1, 5'd31};
        vecs[2] = '{32'h1043_0008, 6'h04, 32'd7, 32'd0, 32'h0000_0008, 5'd3, 5'd0};
        vecs[3] = '{32'h8C24_FFFC, 6'h23, 32'd5, 32'd0, 32'hFFFF_FFFC, 5'd4, 5'd31};

        resetN               = 1'b0;
        bus.instructionValid = 1'b0;
        bus.instruction      = '0;
        bus.writeEnable      = 1'b0;
        bus.writeRegister    = '0;
        bus.writeData        = '0;
        bus.decodeReady      = 1'b1;
        step();
        check("reset valid", 64'(bus.decodeValid), 64'd0);
        check("reset op",    64'(bus.opCode), 64'd0);
        check("reset r1",    64'(bus.readDataNumberOne), 64'd0);
        check("reset imm",   64'(bus.signExtendedImmediate), 64'd0);
        check("reset stall", 64'(bus.hazardStall), 64'd0);
        resetN = 1'b1;
        step();

        write_reg(5'd1, 32'd5);
        write_reg(5'd2, 32'd7);

        for (int i = 0; i < 4; i++) begin
            present(vecs[i].instr);
            #1;
            check($sformatf("vec%0d ready", i), 64'(bus.instructionReady), 64'd1);
            step();
            check_fields($sformatf("vec%0d", i), vecs[i]);
        end

        // lw $4 held, add $5,$4,$1 depends through rs
        present(32'h0081_2820);
        #1;
        check("lu stall",       64'(bus.hazardStall), 64'd1);
        check("lu ready",       64'(bus.instructionReady), 64'd0);
        step();
        check("lu bubble",      64'(bus.decodeValid), 64'd0);
        check("lu stall clr",   64'(bus.hazardStall), 64'd0);
        check("lu ready again", 64'(bus.instructionReady), 64'd1);
        step();
        check_fields("lu add", '{32'h0081_2820, 6'h00, 32'd0, 32'd5, 32'h0000_2820, 5'd1, 5'd5});

        // lw $0 never causes a hazard
        present(32'h8C20_0000);
        step();
        check("lw0 op", 64'(bus.opCode), 64'h23);
        present(32'h0000_2820);
        #1;
        check("lw0 stall", 64'(bus.hazardStall), 64'd0);
        check("lw0 ready", 64'(bus.instructionReady), 64'd1);
        step();

        // sw depends through rt
        present(32'h8C24_FFFC);
        step();
        present(32'hAC44_0000);
        #1;
        check("sw stall", 64'(bus.hazardStall), 64'd1);
        step();
        check("sw bubble", 64'(bus.decodeValid), 64'd0);
        step();
        check("sw valid", 64'(bus.decodeValid), 64'd1);
        check("sw op",    64'(bus.opCode), 64'h2B);
        check("sw r1",    64'(bus.readDataNumberOne), 64'd7);

        // addi writes rt, so rt match alone is not a hazard
        present(32'h8C24_FFFC);
        step();
        present(32'h2044_0001);
        #1;
        check("addi stall", 64'(bus.hazardStall), 64'd0);
        check("addi ready", 64'(bus.instructionReady), 64'd1);
        step();
        check("addi op",  64'(bus.opCode), 64'h08);
        check("addi imm", 64'(bus.signExtendedImmediate), 64'd1);

        bus.instructionValid = 1'b0;
        step();
        check("drain valid", 64'(bus.decodeValid), 64'd0);

        // hold with a write to r1 in the background
        present(32'h0022_1800);
        step();
        bus.decodeReady = 1'b0;
        present(32'h0000_1820);
        bus.writeEnable   = 1'b1;
        bus.writeRegister = 5'd1;
        bus.writeData     = 32'd9;
        for (int c = 0; c < 3; c++) begin
            step();
            bus.writeEnable = 1'b0;
            check($sformatf("hold%0d valid", c), 64'(bus.decodeValid), 64'd1);
            check($sformatf("hold%0d r1", c),    64'(bus.readDataNumberOne), 64'd5);
            check($sformatf("hold%0d rd", c),    64'(bus.rd), 64'd3);
            check($sformatf("hold%0d ready", c), 64'(bus.instructionReady), 64'd0);
        end
        bus.decodeReady = 1'b1;
        step();
        check("release op", 64'(bus.opCode), 64'd0);
        check("release r1", 64'(bus.readDataNumberOne), 64'd0);
        check("release rt", 64'(bus.rt), 64'd0);
        present(32'h0022_1800);
        step();
        check("r1 after hold", 64'(bus.readDataNumberOne), 64'd9);

        // same-edge write and capture of r1
`ifdef REGFILE_BYPASS_EN
        exp_same_edge = 32'd13;
`else
        exp_same_edge = 32'd9;
`endif
        present(32'h0022_1800);
        bus.writeEnable   = 1'b1;
        bus.writeRegister = 5'd1;
        bus.writeData     = 32'd13;
        step();
        check("same edge r1", 64'(bus.readDataNumberOne), 64'(exp_same_edge));
        bus.writeRegister = 5'd0;
        bus.writeData     = 32'hFF;
        present(32'h0040_1820);
        step();
        bus.writeEnable = 1'b0;
        check("r0 same edge", 64'(bus.readDataNumberTwo), 64'd0);
        step();
        check("r0 after write", 64'(bus.readDataNumberTwo), 64'd0);
        present(32'h0022_1800);
        step();
        check("r1 updated", 64'(bus.readDataNumberOne), 64'd13);

        // asynchronous reset mid-cycle
        #2;
        resetN = 1'b0;
        #1;
        check("areset valid", 64'(bus.decodeValid), 64'd0);
        check("areset r1",    64'(bus.readDataNumberOne), 64'd0);
        check("areset rt",    64'(bus.rt), 64'd0);
        check("areset rd",    64'(bus.rd), 64'd0);
        check("areset imm",   64'(bus.signExtendedImmediate), 64'd0);
        step();
        resetN = 1'b1;
        step();
        step();
        check("post reset valid", 64'(bus.decodeValid), 64'd1);
        check("post reset r1",    64'(bus.readDataNumberOne), 64'd0);
        check("post reset r2",    64'(bus.readDataNumberTwo), 64'd0);

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
